// File: rtl/dcntr4_if.sv
// Signal bundle for one dcntr4 stage: load/count controls in, count and status flags out.
interface dcntr4_if;
    logic       pe;
    logic [3:0] p;
    logic       ce;
    logic       ar;
    logic [3:0] q;
    logic       tc;
    logic       done;
    logic       zero;

    modport master (
        output pe, p, ce, ar,
        input  q, tc, done, zero
    );

    modport slave (
        input  pe, p, ce, ar,
        output q, tc, done, zero
    );
endinterface

// File: rtl/dcntr4.sv
// 4-bit loadable down counter with reload register, combinational borrow (tc)
// and a registered done pulse; cascade stages by feeding tc into the next ce.
module dcntr4 (
    input  logic     clk,
    input  logic     reset,
    dcntr4_if.slave  bus
);
    logic [3:0] cnt;
    logic [3:0] rl;
    logic       done_r;
    logic       at_zero;
    logic       tc;
    logic [3:0] cnt_dec;

    assign at_zero = (cnt == 4'h0);
    assign tc      = at_zero && bus.ce;
    // Decrement as an add of all-ones; the carry-out is deliberately dropped.
    assign cnt_dec = cnt + 4'b1111;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            rl     <= '0;
            done_r <= 1'b0;
        end else begin
            if (bus.pe) begin
                cnt <= bus.p;
                rl  <= bus.p;
            end else if (bus.ce) begin
                if (!at_zero)
                    cnt <= cnt_dec;
                else if (bus.ar)
                    cnt <= rl;
                else
                    cnt <= '1;
            end
            // A load coinciding with terminal count swallows the done pulse.
            done_r <= tc && !bus.pe;
        end
    end

    assign bus.q    = cnt;
    assign bus.tc   = tc;
    assign bus.zero = at_zero;
    assign bus.done = done_r;
endmodule

// File: tb/tb_dcntr4.sv
// Randomized and directed bench for dcntr4 against a cycle-level arithmetic model,
// plus a two-stage cascade treated as one 8-bit down counter.
module tb_dcntr4;
    logic clk;
    logic reset;
    logic reset_c;

    dcntr4_if bus ();
    dcntr4_if bus_lo ();
    dcntr4_if bus_hi ();

    dcntr4 dut    (.clk(clk), .reset(reset),   .bus(bus));
    dcntr4 dut_lo (.clk(clk), .reset(reset_c), .bus(bus_lo));
    dcntr4 dut_hi (.clk(clk), .reset(reset_c), .bus(bus_hi));

    assign bus_hi.ce = bus_lo.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_checks = 0;

    int m_q;
    int m_rl;
    int m_done;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic drive(input logic pe, input logic [3:0] p, input logic ce, input logic ar);
        bus.pe = pe;
        bus.p  = p;
        bus.ce = ce;
        bus.ar = ar;
    endtask

    // Check current outputs against the model, then clock once and advance the model.
    task automatic cycle();
        int nq;
        int nd;
        #1;
        chk("q",    bus.q,    8'(m_q));
        chk("zero", bus.zero, 8'(m_q == 0));
        chk("tc",   bus.tc,   8'((m_q == 0) && bus.ce));
        chk("done", bus.done, 8'(m_done));
        nd = ((m_q == 0) && bus.ce && !bus.pe) ? 1 : 0;
        if (bus.pe) begin
            nq   = int'(bus.p);
            m_rl = int'(bus.p);
        end else if (!bus.ce)
            nq = m_q;
        else if (m_q == 0 && bus.ar)
            nq = m_rl;
        else
            nq = (m_q + 15) % 16;
        @(posedge clk);
        #1;
        m_q    = nq;
        m_done = nd;
    endtask

    initial begin
        int val;
        reset   = 1'b0;
        reset_c = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        bus_lo.pe = 1'b0; bus_lo.p = 4'h0; bus_lo.ce = 1'b0; bus_lo.ar = 1'b0;
        bus_hi.pe = 1'b0; bus_hi.p = 4'h0; bus_hi.ar = 1'b0;

        // Held in reset: state stays cleared whatever the inputs do.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            drive(1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
            #1;
            chk("rst_q",    bus.q,    8'h0);
            chk("rst_done", bus.done, 8'h0);
            chk("rst_zero", bus.zero, 8'h1);
            chk("rst_tc",   bus.tc,   8'(bus.ce));
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        m_q = 0; m_rl = 0; m_done = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle();

        // Load 5 and count down through the wrap.
        drive(1'b1, 4'h5, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) cycle();

        // Auto-reload from 3.
        drive(1'b1, 4'h3, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) cycle();

        // Divide-by-1.
        drive(1'b1, 4'h0, 1'b0, 1'b1);
        cycle();
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle();

        // Load beats terminal count and suppresses done.
        drive(1'b1, 4'h9, 1'b1, 1'b0);
        cycle();
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0), 4'($urandom), ($urandom_range(0, 3) != 0),
                  1'($urandom));
            cycle();
        end

        // Two-stage cascade loaded with 8'h10.
        #2;
        reset_c = 1'b1;
        @(posedge clk);
        #1;
        bus_lo.pe = 1'b1; bus_lo.p = 4'h0;
        bus_hi.pe = 1'b1; bus_hi.p = 4'h1;
        @(posedge clk);
        #1;
        bus_lo.pe = 1'b0;
        bus_hi.pe = 1'b0;
        bus_lo.ce = 1'b1;
        val = 16'h10;
        for (int i = 0; i < 18; i++) begin
            #1;
            chk("casc_q",  {bus_hi.q, bus_lo.q}, 8'(val));
            chk("casc_tc", bus_hi.tc, 8'(val == 0));
            @(posedge clk);
            #1;
            val = (val + 255) % 256;
        end
        // Asynchronous reset between edges clears both stages at once.
        #2;
        reset_c = 1'b0;
        #1;
        chk("casc_rst_lo", bus_lo.q, 8'h0);
        chk("casc_rst_hi", bus_hi.q, 8'h0);
        @(posedge clk);
        #1;
        reset_c = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/dcntr4.md
# dcntr4

4-bit loadable down counter with a reload register, terminal-count borrow output and a registered `done` pulse. It pairs with the up counter in the counter/timer datapath. Several stages cascade by chaining `tc` into the next stage's `ce`. A stage in auto-reload mode acts as a programmable divide-by-(N+1) timer.

## Interface

Parameters: none (width fixed at 4 bits).

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `pe`  in  1  parallel load enable; highest priority
- `p`  in  4  parallel load value
- `ce`  in  1  count enable (borrow-in when cascaded)
- `ar`  in  1  auto-reload select: 1 = reload from `rl` at underflow, 0 = wrap to 4'hF
- `q`  out  4  current count (registered)
- `tc`  out  1  terminal count / borrow-out, combinational: `(q == 4'h0) && ce`
- `done`  out  1  registered one-cycle pulse, high the cycle after a `tc` event is consumed
- `zero`  out  1  combinational: `q == 4'h0`, independent of `ce`

## Operation

- Internal state:
  - `q[3:0]`, the count register.
  - `rl[3:0]`, the reload register.
  - `done`, a 1-bit register.
- Next-state priority per rising `clk`, first match wins:
  1. `pe=1`: `q <= p`, `rl <= p`. Applies regardless of `ce` and `ar`.
  2. `ce=1`, `q != 0`: `q <= q - 1`. `rl` holds.
  3. `ce=1`, `q == 0`, `ar=1`: `q <= rl`. This is the reload.
  4. `ce=1`, `q == 0`, `ar=0`: `q <= 4'hF`. This is the modulo-16 wrap.
  5. Otherwise: `q` and `rl` hold.
- `done` next-state = `tc && !pe`. A load in the same cycle as a terminal count suppresses `done`.
- Arithmetic is 4-bit unsigned modulo 16. The decrement is computed as `q + 4'b1111` with carry-in 0. The carry-out is discarded.
- `rl` changes only on `pe`. Reload period in auto-reload mode = `rl + 1` enabled cycles.
  - `rl = 0` with `ar=1`: `q` stays 0 and `tc` asserts on every enabled cycle (divide-by-1).
- Cascading: stage k+1's `ce` = stage k's `tc`.
  - The chain forms a multi-digit down counter.
  - The MSB stage's `tc` is the chain borrow.

## Timing

- Reset (`reset=0`, asynchronous, no clock required):
  - `q=4'h0`, `rl=4'h0`, `done=0`.
  - `zero=1`. `tc` follows `ce`.
- Reset release: first state update at the first rising `clk` after `reset` goes high.
- Reset asserted mid-count clears all state immediately. A pending `done` is lost.
- Load latency: `q` equals `p` one cycle after the `pe` edge.
- Decrement latency: 1 cycle per enabled clock.
- `tc` has zero latency (combinational from `q` and `ce`). It is valid before the same edge that performs the wrap/reload.
- `done` is high for exactly the one cycle following the edge where `tc=1` and `pe=0`.
  - Back-to-back `tc` events (`rl=0`, `ar=1`, `ce` held high) keep `done` high continuously.
- `ce` gaps freeze `q`, `rl` and the sequence. `done` deasserts on the next edge.
- `pe` and `ce` in the same cycle: the load wins. The count does not also decrement.

## Test plan

- Reset: hold `reset=0` with random `pe`/`ce`/`p` and clock running → `q=0`, `done=0`, `zero=1` throughout. After release, with `ce=0`, `q` stays 0.
- Load + count-down: `pe=1, p=4'h5` for one cycle, then `ce=1`, `ar=0`:
  - `q` = 5, 4, 3, 2, 1, 0, F, E…
  - `tc` high only while `q=0`.
  - `done` high for exactly one cycle, when `q=F`.
- Auto-reload: load `p=4'h3`, then `ar=1`, `ce=1` for 12 cycles:
  - `q` = 3, 2, 1, 0, 3, 2, 1, 0, …
  - `tc` pulses every 4 cycles; `done` follows one cycle later.
- Divide-by-1: load `p=0`, `ar=1`, `ce=1` → `q` stays 0, `tc=1` every cycle, `done=1` continuously from the second cycle.
- Priority: at `q=0`, drive `pe=1, p=4'h9, ce=1`:
  - Next `q=9` (no wrap).
  - `done` stays 0 on the next cycle despite `tc=1` in that cycle.
- Cascade / async reset: chain two stages, loaded 8'h10 (high=1, low=0), global `ce=1`:
  - Values read 10, 0F, 0E…00, FF.
  - The MSB-stage borrow `tc` asserts at 00.
  - Assert `reset=0` mid-sequence between clock edges → both `q` clear to 0 before the next edge.
